// File: rtl/fifo_stream_writer.sv
// fifo_stream_writer
//   Write-side producer for the async FIFO (wr_clk domain). Turns an upstream
//   valid/ready packet stream into FIFO writes of {last, data}. A two-entry
//   skid buffer decouples s_ready from the FIFO full flag. Packets longer than
//   MAX_PKT words are cut short: the last kept word gets a forced last, and the
//   rest of the packet is swallowed.
// Ports:
//   wr_clk, rst        clock, synchronous active-high reset
//   s_valid/s_ready    upstream handshake; s_data, s_last payload
//   wr_en/wdata        FIFO write strobe and word {last, data}
//   full, wr_error     FIFO status inputs
//   clr_err            pulse, clears len_err/fifo_err
//   pkt_done, pkt_cnt  packet-written pulse and wrapping packet count
//   len_err, fifo_err  sticky error flags
module fifo_stream_writer #(
  parameter int DATA_W  = 8,
  parameter int MAX_PKT = 16,
  parameter int LEN_W   = $clog2(MAX_PKT + 1)
) (
  input  logic              wr_clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_last,
  output logic              wr_en,
  output logic [DATA_W:0]   wdata,
  input  logic              full,
  input  logic              wr_error,
  input  logic              clr_err,
  output logic              pkt_done,
  output logic [15:0]       pkt_cnt,
  output logic              len_err,
  output logic              fifo_err
);
  localparam int WW = DATA_W + 1;
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_PKT - 1);
  localparam logic SINGLE = (MAX_PKT == 1);

  typedef enum logic [1:0] {IDLE, BODY, DROP} state_t;

  state_t              state_q;
  logic [LEN_W-1:0]    len_cnt_q;
  logic [1:0]          cnt_q, cnt_d;
  logic [1:0][WW-1:0]  buf_q, buf_d;
  logic                pkt_done_q, len_err_q, fifo_err_q;
  logic [15:0]         pkt_cnt_q;

  logic                accept, push, pop, trunc;
  logic [WW-1:0]       push_word;
  logic [1:0]          wr_pos;

  assign s_ready  = (state_q == DROP) || (cnt_q != 2'd2);
  assign wr_en    = (cnt_q != 2'd0) && !full;
  assign wdata    = buf_q[0];
  assign pkt_done = pkt_done_q;
  assign pkt_cnt  = pkt_cnt_q;
  assign len_err  = len_err_q;
  assign fifo_err = fifo_err_q;

  assign accept = s_valid && s_ready;
  assign pop    = wr_en;
  // Word that must be force-terminated because the packet hit MAX_PKT.
  assign trunc  = accept && !s_last &&
                  (((state_q == IDLE) && SINGLE) ||
                   ((state_q == BODY) && (len_cnt_q == LEN_LAST)));

  always_comb begin
    push      = 1'b0;
    push_word = '0;
    if (accept && (state_q != DROP)) begin
      push      = 1'b1;
      push_word = {s_last || trunc, s_data};
    end
  end

  // Push lands behind whatever survives this cycle's pop. A push never
  // coincides with count 2 (s_ready is low then outside DROP, and DROP
  // never pushes), so the slot index is always 0 or 1.
  always_comb begin
    cnt_d  = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_pos = cnt_q - {1'b0, pop};
    buf_d  = buf_q;
    if (pop)  buf_d[0] = buf_q[1];
    if (push) buf_d[wr_pos[0]] = push_word;
  end

  // Packet framing FSM; advances only on accepted words.
  always_ff @(posedge wr_clk) begin
    if (rst) begin
      state_q   <= IDLE;
      len_cnt_q <= '0;
      len_err_q <= 1'b0;
    end else begin
      if (accept) begin
        case (state_q)
          IDLE: if (!s_last) begin
            state_q   <= SINGLE ? DROP : BODY;
            len_cnt_q <= LEN_W'(1);
          end
          BODY: if (s_last) begin
            state_q   <= IDLE;
            len_cnt_q <= '0;
          end else begin
            if (len_cnt_q == LEN_LAST) state_q <= DROP;
            len_cnt_q <= len_cnt_q + LEN_W'(1);
          end
          default: if (s_last) begin
            state_q   <= IDLE;
            len_cnt_q <= '0;
          end
        endcase
      end
      if (trunc)        len_err_q <= 1'b1;
      else if (clr_err) len_err_q <= 1'b0;
    end
  end

  always_ff @(posedge wr_clk) begin
    if (rst) begin
      cnt_q      <= '0;
      buf_q      <= '0;
      pkt_done_q <= 1'b0;
      pkt_cnt_q  <= '0;
      fifo_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
      pkt_done_q <= pop && buf_q[0][DATA_W];
      if (pop && buf_q[0][DATA_W]) pkt_cnt_q <= pkt_cnt_q + 16'd1;
      if (wr_error)     fifo_err_q <= 1'b1;
      else if (clr_err) fifo_err_q <= 1'b0;
    end
  end
endmodule
